// File: rtl/branch_checker.sv
`default_nettype none
// ============================================================================
//  Module      : branch_checker
//  Description : BHT of 2-bit saturating counters, F->D->X prediction pipe,
//                X-stage mispredict check and branch/mispredict counters.
//  Revision    : 1.0
// ============================================================================
module branch_checker #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_f,
    input  logic             fetch_valid_f,
    output logic             predict_taken_f,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      pc_x,
    input  logic             is_branch_x,
    input  logic             taken_x,
    output logic [2:0]       result,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int         c_DEPTH     = 1 << IDX_BITS;
    localparam logic [1:0] c_BHT_RESET = 2'b01;
    localparam logic [2:0] c_RES_NONE  = 3'b000;
    localparam logic [2:0] c_RES_OK_NT = 3'b001;
    localparam logic [2:0] c_RES_OK_T  = 3'b010;
    localparam logic [2:0] c_RES_MISS  = 3'b100;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]          r_bht [c_DEPTH];
    logic                r_pd_valid;
    logic                r_pd_pred;
    logic                r_px_valid;
    logic                r_px_pred;
    logic [CNT_W-1:0]    r_branch_cnt;
    logic [CNT_W-1:0]    r_mispred_cnt;

    logic [IDX_BITS-1:0] w_idx_f;
    logic [IDX_BITS-1:0] w_idx_x;
    logic [1:0]          w_bht_cur;
    logic [1:0]          w_bht_next;
    logic                w_update;
    logic [2:0]          w_result;
    logic                w_unused_pc;

    assign w_idx_f     = pc_f[IDX_BITS+1:2];
    assign w_idx_x     = pc_x[IDX_BITS+1:2];
    assign w_unused_pc = ^{pc_f[31:IDX_BITS+2], pc_f[1:0], pc_x[31:IDX_BITS+2], pc_x[1:0]};

    // Read is from the registered table, so a same-index update is not visible until the next cycle.
    assign predict_taken_f = r_bht[w_idx_f][1];

    always_comb begin
        w_result = c_RES_NONE;
        if (r_px_valid && is_branch_x) begin
            if (r_px_pred != taken_x) begin
                w_result = c_RES_MISS;
            end else if (r_px_pred) begin
                w_result = c_RES_OK_T;
            end else begin
                w_result = c_RES_OK_NT;
            end
        end
    end

    assign result   = w_result;
    // A stalled branch keeps presenting its result; it is counted once, when the stall lifts.
    assign w_update = (w_result != c_RES_NONE) && !stall;

    always_comb begin
        w_bht_cur  = r_bht[w_idx_x];
        w_bht_next = w_bht_cur;
        if (taken_x) begin
            if (w_bht_cur != 2'b11) begin
                w_bht_next = w_bht_cur + 2'b01;
            end
        end else begin
            if (w_bht_cur != 2'b00) begin
                w_bht_next = w_bht_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bht[i] <= c_BHT_RESET;
            end
        end else if (w_update) begin
            r_bht[w_idx_x] <= w_bht_next;
        end
    end

    // Flush beats stall: wrong-path slots must be killed even while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pd_valid <= 1'b0;
            r_pd_pred  <= 1'b0;
            r_px_valid <= 1'b0;
            r_px_pred  <= 1'b0;
        end else if (flush) begin
            r_pd_valid <= 1'b0;
            r_px_valid <= 1'b0;
        end else if (!stall) begin
            r_pd_valid <= fetch_valid_f;
            r_pd_pred  <= predict_taken_f;
            r_px_valid <= r_pd_valid;
            r_px_pred  <= r_pd_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_update) begin
            r_branch_cnt <= r_branch_cnt + c_CNT_ONE;
            if (w_result == c_RES_MISS) begin
                r_mispred_cnt <= r_mispred_cnt + c_CNT_ONE;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_checker
//  Description : Scoreboard bench for branch_checker with directed vectors.
//  Revision    : 1.0
// ============================================================================
module tb_branch_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        fetch_valid_f;
    logic        stall;
    logic        flush;
    logic [31:0] pc_x;
    logic        is_branch_x;
    logic        taken_x;

    logic        predict_taken_f;
    logic [2:0]  result;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    logic        pred_w;
    logic [2:0]  result_w;
    logic [2:0]  bcnt_w;
    logic [2:0]  mcnt_w;

    always #5 clk = ~clk;

    branch_checker #(.IDX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .fetch_valid_f(fetch_valid_f),
        .predict_taken_f(predict_taken_f), .stall(stall), .flush(flush),
        .pc_x(pc_x), .is_branch_x(is_branch_x), .taken_x(taken_x),
        .result(result), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // Narrow-counter copy driven identically, so counter wrap is reached quickly.
    branch_checker #(.IDX_BITS(6), .CNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .pc_f(pc_f), .fetch_valid_f(fetch_valid_f),
        .predict_taken_f(pred_w), .stall(stall), .flush(flush),
        .pc_x(pc_x), .is_branch_x(is_branch_x), .taken_x(taken_x),
        .result(result_w), .branch_cnt(bcnt_w), .mispred_cnt(mcnt_w)
    );

    typedef struct {
        logic [2:0]  res;
        int unsigned b;
        int unsigned m;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the X stage presents a branch, pop and compare.
    always @(negedge clk) begin
        if (!rst && is_branch_x) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: result %0b seen with no expected entry", result);
            end else begin
                e = sb.pop_front();
                chk("result", {29'd0, result}, {29'd0, e.res});
                chk("branch_cnt", branch_cnt, e.b);
                chk("mispred_cnt", mispred_cnt, e.m);
                chk("result_narrow", {29'd0, result_w}, {29'd0, e.res});
                chk("branch_cnt_wrap", {29'd0, bcnt_w}, e.b % 8);
                chk("mispred_cnt_wrap", {29'd0, mcnt_w}, e.m % 8);
            end
        end
    end

    // One cycle: drive, optionally check the prediction, push expectation, advance.
    task automatic cyc(input logic fv, input logic [31:0] pcf, input logic br,
                       input logic [31:0] pcx, input logic tk, input logic st,
                       input logic fl, input logic [2:0] eres,
                       input int unsigned eb, input int unsigned em, input int epred);
        exp_t x;
        fetch_valid_f = fv;
        pc_f          = pcf;
        is_branch_x   = br;
        pc_x          = pcx;
        taken_x       = tk;
        stall         = st;
        flush         = fl;
        if (br) begin
            x.res = eres;
            x.b   = eb;
            x.m   = em;
            sb.push_back(x);
        end
        #1;
        if (epred >= 0) begin
            chk("predict_taken_f", {31'd0, predict_taken_f}, epred[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [31:0] pc, input logic tk, input int epred,
                          input logic [2:0] eres, input int unsigned eb, input int unsigned em);
        cyc(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, epred);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, -1);
        cyc(1'b0, 32'h0, 1'b1, pc, tk, 1'b0, 1'b0, eres, eb, em, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_f = 32'h100; fetch_valid_f = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_x = 32'h0; is_branch_x = 1'b0; taken_x = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_predict", {31'd0, predict_taken_f}, 32'd0);
        chk("reset_result", {29'd0, result}, 32'd0);
        chk("reset_branch_cnt", branch_cnt, 32'd0);
        chk("reset_mispred_cnt", mispred_cnt, 32'd0);
        @(posedge clk);
        #1;

        // Index 0 walk: 01 -> 10 -> 11 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01
        branch(32'h100, 1'b1, 0, 3'b100, 0, 0);
        branch(32'h100, 1'b1, 1, 3'b010, 1, 1);
        branch(32'h100, 1'b1, 1, 3'b010, 2, 1);
        branch(32'h100, 1'b1, 1, 3'b010, 3, 1);
        chk("cnt_after_4_branch", branch_cnt, 32'd4);
        chk("cnt_after_4_mispred", mispred_cnt, 32'd1);
        branch(32'h100, 1'b0, 1, 3'b100, 4, 1);
        branch(32'h100, 1'b0, 1, 3'b100, 5, 2);
        branch(32'h100, 1'b0, 0, 3'b001, 6, 3);
        branch(32'h100, 1'b0, 0, 3'b001, 7, 3);
        branch(32'h100, 1'b1, 0, 3'b100, 8, 3);

        // Flush with a valid branch in X: X branch updates, next slot is wrong-path
        cyc(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0);
        cyc(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, -1);
        cyc(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 3'b100, 9, 4, -1);
        cyc(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 3'b000, 10, 5, -1);
        chk("flush_branch_cnt", branch_cnt, 32'd10);
        chk("flush_mispred_cnt", mispred_cnt, 32'd5);
        branch(32'h104, 1'b0, 1, 3'b100, 10, 5);
        branch(32'h104, 1'b1, 0, 3'b100, 11, 6);

        // Stall three cycles with a mispredicting branch in X; fetches during stall must not enter
        cyc(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, -1);
        repeat (3) cyc(1'b1, 32'h108, 1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 3'b100, 12, 7, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 3'b100, 12, 7, -1);
        cyc(1'b0, 32'h108, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 3'b000, 13, 8, 1);

        // Same-index lookup and update in one cycle: read-before-write
        cyc(1'b1, 32'h10C, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, -1);
        cyc(1'b1, 32'h10C, 1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 3'b100, 13, 8, 0);
        cyc(1'b0, 32'h10C, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 1);

        chk("final_branch_cnt", branch_cnt, 32'd14);
        chk("final_mispred_cnt", mispred_cnt, 32'd9);
        chk("final_branch_cnt_wrap", {29'd0, bcnt_w}, 32'd6);
        chk("final_mispred_cnt_wrap", {29'd0, mcnt_w}, 32'd1);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_checker.md
Name: branch_checker

Overview:
- Owns the branch history table (BHT) of 2-bit saturating counters.
- Supplies the fetch-stage taken/not-taken prediction and carries it alongside the instruction through the F->D and D->X boundaries.
- In X, compares the carried prediction with the resolved outcome and emits the 3-bit result code that the downstream flusher decodes; 3'b100 means flush the FD registers.
- Also maintains branch and mispredict performance counters.

Parameters:
- IDX_BITS, 6, BHT index width; table depth = 2^IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_f  input  32  PC of the instruction in F.
- fetch_valid_f  input  1  F holds a real instruction.
- predict_taken_f  output  1  combinational BHT prediction for pc_f.
- stall  input  1  freezes the F->D and D->X prediction registers.
- flush  input  1  from the flusher; invalidates the D and X prediction registers.
- pc_x  input  32  PC of the instruction in X.
- is_branch_x  input  1  X holds a conditional branch.
- taken_x  input  1  resolved branch outcome in X.
- result  output  3  X-stage check code (encoding below).
- branch_cnt  output  CNT_W  branches resolved since reset.
- mispred_cnt  output  CNT_W  mispredicts since reset.

Behaviour:
- BHT counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- predict_taken_f = bht[pc_f index][1], purely combinational, independent of fetch_valid_f.
- Prediction pipe has two registers, each holding {valid, pred}:
  - F->D: pd <= {fetch_valid_f, predict_taken_f}.
  - D->X: px <= pd.
- Pipe priority per cycle: rst > flush > stall > advance.
  - flush: pd.valid <= 0 and px.valid <= 0 (both wrong-path).
  - stall (no flush): pd and px hold.
- Result is combinational on the px registers, is_branch_x and taken_x:
  - 3'b000: no checked branch (px.valid=0 or is_branch_x=0).
  - 3'b001: correct, predicted not-taken.
  - 3'b010: correct, predicted taken.
  - 3'b100: mispredict, whether predicted T resolved NT or predicted NT resolved T.
  - Codes 011, 101, 110 and 111 are never produced.
- Zero-cycle latency from taken_x to result, so the flush fires in the same cycle the branch resolves.
- BHT update occurs on the clock edge when result != 000 and stall == 0:
  - Entry is bht[pc_x index].
  - Increment if taken_x, decrement otherwise.
  - Saturate at 11 and 00; no wrap.
- Lookup/update to the same index in the same cycle: predict_taken_f returns the pre-update value (read-before-write).
- Performance counters, updated on the same qualifying edge as the BHT:
  - branch_cnt += 1.
  - mispred_cnt += 1 when result == 100.
  - Both wrap modulo 2^CNT_W.
- While stall = 1, result stays valid, but the BHT and counters do not update until the stall clears. The update happens exactly once per resolved branch.
- Reset values:
  - All BHT entries = 01 (weak NT).
  - pd and px = {0,0}, so result = 000 after reset.
  - branch_cnt = 0 and mispred_cnt = 0.
  - predict_taken_f = 0 after reset.
- Reset mid-operation clears everything on that edge; an in-flight branch is dropped with no update.
- flush and a qualifying update in the same cycle: the update for the X branch still occurs (that branch is architecturally valid); only pd and px are invalidated.

Test Plan:
- Reset, then fetch pc_f=0x100 -> predict_taken_f=0. Two cycles later is_branch_x=1, taken_x=1, pc_x=0x100 -> result=100. Next cycle bht[0x100 index]=10, mispred_cnt=1, branch_cnt=1.
- Same branch resolved taken three more times -> results 010, 010, 010. Counter saturates at 11. branch_cnt=4, mispred_cnt=1.
- Strong-T entry resolved not-taken twice -> result 100 then 100 (11->10 still predicts T, 10->01). Third fetch predicts 0.
- flush asserted with valid predictions in pd and px -> next cycle result=000 even with is_branch_x=1. No BHT or counter change from that wrong-path slot.
- stall held 3 cycles with a mispredicting branch in X -> result=100 throughout; pd and px unchanged. mispred_cnt increments exactly once, on the edge after stall drops.
- Same-index lookup and update in the same cycle, entry 01, taken_x=1 -> predict_taken_f=0 that cycle and 1 the next. Preset branch_cnt to 2^CNT_W-1 (forced) -> wraps to 0.
